// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding, R/W codes and slave addresses for the I2C master
package i2c_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_ADDR_ACK = 3'd3;
    localparam logic [2:0] ST_WR_DATA  = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_DATA_ACK = 3'd6;
    localparam logic [2:0] ST_STOP     = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_START    = ST_START,
        S_ADDR     = ST_ADDR,
        S_ADDR_ACK = ST_ADDR_ACK,
        S_WR_DATA  = ST_WR_DATA,
        S_RD_DATA  = ST_RD_DATA,
        S_DATA_ACK = ST_DATA_ACK,
        S_STOP     = ST_STOP
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Slaves behind the address translator
    localparam logic [6:0] I2C_SLAVE_ADDR_A = 7'h48;
    localparam logic [6:0] I2C_SLAVE_ADDR_B = 7'h49;

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - quarter-period timebase producing q index, sample and slot_end strobes
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic [1:0] q,
    output logic       sample,
    output logic       slot_end
);

    logic [7:0] qcnt;
    logic       q_last;

    assign q_last = (qcnt == 8'(CLK_DIV - 1));

    // Held at zero while idle so the first slot of a transaction starts aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qcnt <= 8'd0;
            q    <= 2'd0;
        end else if (!run) begin
            qcnt <= 8'd0;
            q    <= 2'd0;
        end else if (q_last) begin
            qcnt <= 8'd0;
            q    <= q + 2'd1;
        end else begin
            qcnt <= qcnt + 8'd1;
        end
    end

    assign sample   = run && q_last && (q == 2'd2);
    assign slot_end = run && q_last && (q == 2'd3);

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C master: START, address, one data byte, STOP
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       scl,
    inout  wire        sda,
    output logic [7:0] rdata,
    output logic       done,
    output logic       nack_err,
    output logic       busy
);

    i2c_state_e state, state_nx;

    logic [2:0] bit_cnt;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q;
    logic [7:0] rx_sr;
    logic       ack_bit;
    logic [1:0] q;
    logic       sample;
    logic       slot_end;
    logic       byte_last;
    logic [7:0] tx_byte;
    logic       tx_bit;
    logic       scl_c;
    logic       sda_low;
    logic       sda_in;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .run      (state != S_IDLE),
        .q        (q),
        .sample   (sample),
        .slot_end (slot_end)
    );

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign byte_last = slot_end && (bit_cnt == 3'd7);
    assign tx_byte   = (state == S_ADDR) ? {addr_q, rw_q} : wdata_q;
    assign tx_bit    = tx_byte[3'd7 - bit_cnt];

    // Open-drain pad; a released line reads back high via the external pull-up
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;
    assign scl    = scl_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        scl_c    = 1'b1;
        sda_low  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) state_nx = S_START;
            end
            S_START: begin
                sda_low = q[1];
                if (slot_end) state_nx = S_ADDR;
            end
            S_ADDR: begin
                scl_c   = q[1];
                sda_low = !tx_bit;
                if (byte_last) state_nx = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                scl_c = q[1];
                if (slot_end) begin
                    if (ack_bit)                  state_nx = S_STOP;
                    else if (rw_q == I2C_RW_READ) state_nx = S_RD_DATA;
                    else                          state_nx = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                scl_c   = q[1];
                sda_low = !tx_bit;
                if (byte_last) state_nx = S_DATA_ACK;
            end
            S_RD_DATA: begin
                scl_c = q[1];
                if (byte_last) state_nx = S_DATA_ACK;
            end
            S_DATA_ACK: begin
                scl_c = q[1];
                if (slot_end) state_nx = S_STOP;
            end
            S_STOP: begin
                scl_c   = q[1];
                sda_low = (q != 2'd3);
                if (slot_end) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= 3'd0;
            addr_q   <= 7'd0;
            rw_q     <= 1'b0;
            wdata_q  <= 8'd0;
            rx_sr    <= 8'd0;
            ack_bit  <= 1'b0;
            rdata    <= 8'd0;
            done     <= 1'b0;
            nack_err <= 1'b0;
        end else begin
            done <= (state == S_STOP) && slot_end;
            if (state == S_IDLE && cmd_valid) begin
                addr_q   <= cmd_addr;
                rw_q     <= cmd_rw;
                wdata_q  <= cmd_wdata;
                nack_err <= 1'b0;
            end
            if (slot_end && (state == S_ADDR || state == S_WR_DATA || state == S_RD_DATA))
                bit_cnt <= bit_cnt + 3'd1;
            if (sample && state == S_RD_DATA)
                rx_sr <= {rx_sr[6:0], sda_in};
            if (byte_last && state == S_RD_DATA)
                rdata <= rx_sr;
            if (sample && (state == S_ADDR_ACK || state == S_DATA_ACK))
                ack_bit <= sda_in;
            // A read always ends in our own NACK, so only address and write-data NACKs are errors
            if (slot_end && ack_bit &&
                (state == S_ADDR_ACK || (state == S_DATA_ACK && rw_q == I2C_RW_WRITE)))
                nack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - self-checking bench with bus monitor, slave model and transaction reference model
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mon_clr = 1'b1;
    logic [1:0] cmd_valid = 2'b00;
    logic [1:0] cmd_rw = 2'b00;
    logic [6:0] cmd_addr [2];
    logic [7:0] cmd_wdata [2];
    logic [1:0] cmd_ready, scl, done, nack_err, busy;
    logic [7:0] rdata [2];
    logic [7:0] slv_rdata [2];
    logic [1:0] slv_dack = 2'b11;
    logic [7:0] exp_rdata [2];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    // Bus 0 runs CLK_DIV=2, bus 1 runs CLK_DIV=1; each has its own slave and monitor
    for (genvar g = 0; g < 2; g++) begin : gen_bus
        wire         sda_w;
        logic        pull = 1'b0;
        logic        scl_p = 1'b1, sda_p = 1'b1;
        logic        in_xfer = 1'b0, acked = 1'b0, rd_mode = 1'b0;
        logic [31:0] log_bits = 32'd0;
        int          nbits = 0, starts = 0, stops = 0, dones = 0;

        pullup (sda_w);
        assign sda_w = pull ? 1'b0 : 1'bz;

        i2c_master_ctrl #(.CLK_DIV(g == 0 ? 2 : 1)) dut (
            .clk(clk), .reset(reset), .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_addr(cmd_addr[g]), .cmd_rw(cmd_rw[g]), .cmd_wdata(cmd_wdata[g]),
            .scl(scl[g]), .sda(sda_w), .rdata(rdata[g]), .done(done[g]),
            .nack_err(nack_err[g]), .busy(busy[g])
        );

        always @(posedge clk) if (done[g]) dones <= dones + 1;

        always @(negedge clk) begin
            scl_p <= scl[g];
            sda_p <= sda_w;
            if (mon_clr) begin
                in_xfer <= 1'b0;
                pull    <= 1'b0;
                nbits   <= 0;
            end else if (scl_p && scl[g] && sda_p && !sda_w) begin
                starts   <= starts + 1;
                in_xfer  <= 1'b1;
                nbits    <= 0;
                log_bits <= 32'd0;
            end else if (scl_p && scl[g] && !sda_p && sda_w) begin
                stops   <= stops + 1;
                in_xfer <= 1'b0;
                pull    <= 1'b0;
            end else if (in_xfer && !scl_p && scl[g]) begin
                log_bits <= {log_bits[30:0], sda_w};
                nbits    <= nbits + 1;
            end else if (in_xfer && scl_p && !scl[g]) begin
                if (nbits == 8) begin
                    acked   <= (log_bits[7:1] == I2C_SLAVE_ADDR_A) || (log_bits[7:1] == I2C_SLAVE_ADDR_B);
                    rd_mode <= log_bits[0];
                    pull    <= (log_bits[7:1] == I2C_SLAVE_ADDR_A) || (log_bits[7:1] == I2C_SLAVE_ADDR_B);
                end else if (nbits >= 9 && nbits <= 16)
                    pull <= acked && rd_mode && !slv_rdata[g][3'(16 - nbits)];
                else if (nbits == 17)
                    pull <= acked && !rd_mode && slv_dack[g];
                else
                    pull <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void get_mon(input int b, output logic [31:0] bits, output int n,
                                    output int st, output int sp, output int dc);
        if (b == 0) begin
            bits = gen_bus[0].log_bits; n = gen_bus[0].nbits;
            st = gen_bus[0].starts; sp = gen_bus[0].stops; dc = gen_bus[0].dones;
        end else begin
            bits = gen_bus[1].log_bits; n = gen_bus[1].nbits;
            st = gen_bus[1].starts; sp = gen_bus[1].stops; dc = gen_bus[1].dones;
        end
    endfunction

    function automatic logic sda_of(input int b);
        return (b == 0) ? gen_bus[0].sda_w : gen_bus[1].sda_w;
    endfunction

    // Transaction-level expectation: bits seen at each SCL rise between START and STOP
    function automatic void model(input int b, input logic [6:0] a, input logic rw,
                                  input logic [7:0] wd, input logic [7:0] rd, input logic dack,
                                  output logic [31:0] bits, output int n, output int lat,
                                  output logic nack);
        int d = (b == 0) ? 2 : 1;
        logic hit = (a == I2C_SLAVE_ADDR_A) || (a == I2C_SLAVE_ADDR_B);
        if (!hit) begin
            bits = {22'd0, a, rw, 1'b1, 1'b0};
            n = 10; lat = 44 * d + 1; nack = 1'b1;
        end else begin
            bits = {13'd0, a, rw, 1'b0, (rw ? rd : wd), (rw ? 1'b1 : !dack), 1'b0};
            n = 19; lat = 80 * d + 1; nack = !rw && !dack;
            if (rw == I2C_RW_READ) exp_rdata[b] = rd;
        end
    endfunction

    task automatic issue(input int b, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        @(negedge clk);
        cmd_valid[b] = 1'b1; cmd_addr[b] = a; cmd_rw[b] = rw; cmd_wdata[b] = wd;
        @(posedge clk); #1;
        check("busy_after_accept", busy[b], 1'b1);
        check("ready_after_accept", cmd_ready[b], 1'b0);
    endtask

    // Called in cycle 1 of a transaction; returns in the done cycle
    task automatic expect_done(input int b, input int lat_exp, input logic [31:0] bits_exp,
                               input int n_exp, input logic nack_exp);
        int cycles = 1;
        logic [31:0] bits; int n, st, sp, dc;
        while (!done[b] && cycles < lat_exp + 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        get_mon(b, bits, n, st, sp, dc);
        check("latency", cycles, lat_exp);
        check("done", done[b], 1'b1);
        check("busy_at_done", busy[b], 1'b0);
        check("ready_at_done", cmd_ready[b], 1'b1);
        check("nack_err", nack_err[b], nack_exp);
        check("rdata", rdata[b], exp_rdata[b]);
        check("bus_bit_count", n, n_exp);
        check("bus_bits", bits, bits_exp);
    endtask

    task automatic run_one(input int b, input logic [6:0] a, input logic rw,
                           input logic [7:0] wd, input logic [7:0] rd, input logic dack);
        logic [31:0] bits_exp, bits; int n_exp, lat, n, st0, sp0, dc0, st, sp, dc;
        logic nack;
        slv_rdata[b] = rd; slv_dack[b] = dack;
        model(b, a, rw, wd, rd, dack, bits_exp, n_exp, lat, nack);
        get_mon(b, bits, n, st0, sp0, dc0);
        issue(b, a, rw, wd);
        cmd_valid[b] = 1'b0;
        expect_done(b, lat, bits_exp, n_exp, nack);
        @(posedge clk); #1;
        get_mon(b, bits, n, st, sp, dc);
        check("done_one_cycle", done[b], 1'b0);
        check("start_count", st - st0, 1);
        check("stop_count", sp - sp0, 1);
        check("done_count", dc - dc0, 1);
    endtask

    initial begin
        logic [31:0] ba, bb, bits; int na, nb, la, lb, n, st0, sp0, dc0, st, sp, dc, cycles;
        logic nka, nkb, rw;
        logic [6:0] a; logic [7:0] wd, rd;

        for (int i = 0; i < 2; i++) begin
            cmd_addr[i] = 7'd0; cmd_wdata[i] = 8'd0; slv_rdata[i] = 8'd0; exp_rdata[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_scl", scl[i], 1'b1);
            check("rst_sda", sda_of(i), 1'b1);
            check("rst_ready", cmd_ready[i], 1'b1);
            check("rst_busy", busy[i], 1'b0);
            check("rst_done", done[i], 1'b0);
            check("rst_nack", nack_err[i], 1'b0);
            check("rst_rdata", rdata[i], 8'd0);
        end
        @(negedge clk); reset = 1'b1; mon_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Directed: write ACKed, read, address NACK
        run_one(0, I2C_SLAVE_ADDR_A, I2C_RW_WRITE, 8'hA5, 8'h00, 1'b1);
        run_one(0, I2C_SLAVE_ADDR_B, I2C_RW_READ, 8'h00, 8'h3C, 1'b1);
        run_one(0, 7'h50, I2C_RW_WRITE, 8'h11, 8'h00, 1'b1);
        run_one(0, I2C_SLAVE_ADDR_A, I2C_RW_WRITE, 8'h5A, 8'h00, 1'b0);

        // Back-to-back with cmd_valid held high
        rw = 1'($urandom_range(0, 1)); rd = 8'($urandom); wd = 8'($urandom);
        slv_rdata[0] = rd; slv_dack[0] = 1'b1;
        model(0, I2C_SLAVE_ADDR_A, rw, wd, rd, 1'b1, ba, na, la, nka);
        get_mon(0, bits, n, st0, sp0, dc0);
        issue(0, I2C_SLAVE_ADDR_A, rw, wd);
        wd = 8'($urandom);
        cmd_addr[0] = I2C_SLAVE_ADDR_B; cmd_rw[0] = I2C_RW_WRITE; cmd_wdata[0] = wd;
        model(0, I2C_SLAVE_ADDR_B, I2C_RW_WRITE, wd, rd, 1'b1, bb, nb, lb, nkb);
        expect_done(0, la, ba, na, nka);
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        check("b2b_second_accept", busy[0], 1'b1);
        check("b2b_done_low", done[0], 1'b0);
        expect_done(0, lb, bb, nb, nkb);
        @(posedge clk); #1;
        get_mon(0, bits, n, st, sp, dc);
        check("b2b_starts", st - st0, 2);
        check("b2b_stops", sp - sp0, 2);
        check("b2b_dones", dc - dc0, 2);

        // Reset during write-data bit 3, in the SCL-low half of the slot
        get_mon(0, bits, n, st0, sp0, dc0);
        slv_dack[0] = 1'b1;
        issue(0, I2C_SLAVE_ADDR_A, I2C_RW_WRITE, 8'hC3);
        cmd_valid[0] = 1'b0;
        cycles = 1;
        while (cycles < 107) begin @(posedge clk); #1; cycles++; end
        check("pre_reset_busy", busy[0], 1'b1);
        reset = 1'b0; mon_clr = 1'b1;
        exp_rdata[0] = 8'd0; exp_rdata[1] = 8'd0;
        @(posedge clk); #1;
        check("mid_rst_scl", scl[0], 1'b1);
        check("mid_rst_sda", sda_of(0), 1'b1);
        check("mid_rst_busy", busy[0], 1'b0);
        check("mid_rst_ready", cmd_ready[0], 1'b1);
        check("mid_rst_rdata", rdata[0], 8'd0);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk); reset = 1'b1; mon_clr = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        get_mon(0, bits, n, st, sp, dc);
        check("mid_rst_no_done", dc - dc0, 0);
        check("mid_rst_no_stop", sp - sp0, 0);
        run_one(0, I2C_SLAVE_ADDR_A, I2C_RW_WRITE, 8'h96, 8'h00, 1'b1);

        // CLK_DIV=1 bus
        run_one(1, I2C_SLAVE_ADDR_B, I2C_RW_WRITE, 8'hFF, 8'h00, 1'b1);
        run_one(1, I2C_SLAVE_ADDR_A, I2C_RW_READ, 8'h00, 8'hC9, 1'b1);

        // Randomized transactions on both buses
        for (int i = 0; i < 14; i++) begin
            int b = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = I2C_SLAVE_ADDR_A;
                1:       a = I2C_SLAVE_ADDR_B;
                default: a = 7'h20 | 7'($urandom_range(0, 31));
            endcase
            run_one(b, a, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Single-master I2C initiator that drives the far end of the bus our address translator bridges. It accepts one command per transaction: 7-bit address, R/W and one data byte. It generates START, the address byte, one data byte (written, or read and NACKed) and STOP. It reports the read data, address/data NACK and completion to the local controller. There is no multi-master arbitration and no clock stretching.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV clk); legal range 1..255.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; command accepted on cmd_valid & cmd_ready
cmd_addr  in  7  target 7-bit address
cmd_rw  in  1  0=write, 1=read
cmd_wdata  in  8  byte to write (ignored on read)
scl  out  1  bus clock, push-pull
sda  inout  1  open-drain: driven 0 or released (z), never driven 1
rdata  out  8  byte read; valid when done=1 and the read succeeded
done  out  1  one-clk pulse at end of transaction
nack_err  out  1  valid with done: 1 if address or write-data was NACKed
busy  out  1  high from accept until done

Behaviour:
- Reset (asynchronous): state IDLE; scl=1; sda released; cmd_ready=1; busy=0; done=0; nack_err=0; rdata=0; all counters 0.
- Timebase: quarter counter qcnt counts 0..CLK_DIV-1. Quarter index q cycles 0..3. Every bus slot lasts exactly 4 quarters.
- Accept: in IDLE, cmd_valid=1 latches addr, rw and wdata; busy=1 and cmd_ready=0 on the next clk. cmd_valid is ignored while busy.
- Data bit slot: sda is set at the start of q0. scl=0 in q0-q1 and scl=1 in q2-q3. sda is sampled on the last clk of q2.
- States, one slot each unless noted:
  - IDLE
  - START: sda released in q0-q1, driven 0 in q2-q3; scl=1 throughout.
  - ADDR: 8 slots, MSB first, addr[6:0] then rw.
  - ADDR_ACK: sda released; a sampled 0 is ACK.
  - WR_DATA: 8 slots, MSB first.
  - RD_DATA: 8 slots, sda released, shift in MSB first.
  - DATA_ACK: on write, sample the ACK; on read, the master releases sda (NACK).
  - STOP: sda driven 0 in q0-q2, released in q3; scl=0 in q0-q1, scl=1 in q2-q3.
  - Then IDLE.
- Transitions:
  - ADDR_ACK with ACK goes to WR_DATA or RD_DATA per rw.
  - ADDR_ACK with NACK sets nack_err and goes straight to STOP.
  - Write-data NACK sets nack_err; STOP follows regardless.
- Completion: done pulses for 1 clk on the first cycle back in IDLE. busy falls in the same cycle. cmd_ready rises in the same cycle. A new command can be accepted in that cycle.
- rdata updates only at the end of RD_DATA. It holds its value otherwise, including across write transactions.
- Latency, accept to done, ACKed transaction: 20 slots = 80*CLK_DIV clk, +1 cycle. NACKed address: 11 slots = 44*CLK_DIV clk, +1.
- Bit counter is 3 bits and wraps 7->0 on each byte boundary.
- sda read is treated as high when released (pull-up is external; the bench uses weak pull-up).
- Reset mid-transfer: immediate return to reset values. No STOP is generated, and no done pulse is produced.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding localparams (IDLE..STOP, 3 bits);
  - I2C_RW_WRITE=0 and I2C_RW_READ=1;
  - the translator's slave addresses 7'h48 and 7'h49.
- Sub-module i2c_quarter_tick generates the q index and a slot_end strobe from CLK_DIV.
- The FSM, shift registers and pin logic stay in i2c_master_ctrl.

Test Plan:
- Write, CLK_DIV=2, addr 0x48, wdata 0xA5, slave ACKs both bytes -> SDA bits 1001000 0 A 10100101 A. START and STOP are observed with scl=1. done at cycle 161. nack_err=0.
- Read, addr 0x49, slave model returns 0x3C -> address byte 0x93 on the bus. Master releases sda on the 9th data slot (NACK). rdata=0x3C and nack_err=0 at done.
- Address NACK, addr 0x50, no slave -> no data slots; STOP follows ADDR_ACK. done after 44*CLK_DIV+1 clk with nack_err=1. rdata unchanged.
- Back-to-back: cmd_valid held high for two commands; pulses during busy are ignored -> the second command is accepted in the done cycle, and exactly two transactions appear on the bus.
- Reset asserted mid-WR_DATA (bit 3) -> next clk: scl=1, sda=z, busy=0, cmd_ready=1, no done pulse. A following write completes normally.
- CLK_DIV=1 -> each SCL period is 4 clk. Write 0x49/0xFF passes the same bit check.
